hc154_line_driver: RTL and testbench
====================================

Name: hc154_line_driver

Overview:
- Inverse of the board's 16-line priority encoder front end (cascaded 74HC148 pair, 4-bit code, 7-segment decode).
- Accepts a 4-bit code over a valid/ready handshake and drives exactly one of 16 active-low lines for a fixed pulse width, then observes a recovery gap.
- Used as the stimulus source for the encoder/display path, and for keypad emulation on the test board.
- Out-of-range codes (> MAX_CODE) are rejected with an error pulse. This mirrors the display path blanking codes >= 10.

Parameters:
- HOLD_CYCLES, 4, clock cycles a decoded line is held low (legal 1..255).
- GAP_CYCLES, 2, clock cycles all lines are held high after a pulse before the next accept (legal 0..255).
- MAX_CODE, 9, largest code that is driven; larger codes raise Err.
- CNT_W, 8, width of the internal hold/gap counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RESETn  input  1  asynchronous active-low reset.
- EI  input  1  active-low enable (74HC148 EI sense); high = block disabled.
- Code  input  4  line number to drive, 0..15.
- Valid  input  1  Code is valid this cycle.
- Ready  output  1  block can accept a code this cycle.
- DataOut  output  8  active-low lines 8..15 (line k on DataOut[k-8]).
- DataOut_0  output  8  active-low lines 0..7 (line k on DataOut_0[k]).
- Busy  output  1  high while a pulse or gap is in progress.
- Err  output  1  one-cycle pulse on acceptance of a code > MAX_CODE.

Behaviour:
- Clocking and reset: one clock domain (CLK). RESETn is asynchronous and active-low.
- Reset values:
  - DataOut = 8'hFF, DataOut_0 = 8'hFF.
  - Ready = 0, Busy = 0, Err = 0.
  - State = IDLE, counter = 0, code register = 0.
- All outputs are registered.
- Ready:
  - Rises at the first CLK edge after RESETn deasserts, provided EI = 0.
  - Equals 1 only in IDLE with EI = 0.
- Accept: occurs on a rising edge where Valid = 1 and Ready = 1. Code is captured on that edge.
- States:
  - IDLE: lines all high.
    - Accept with Code <= MAX_CODE → DRIVE, counter = HOLD_CYCLES-1.
    - Accept with Code > MAX_CODE → Err = 1 for the next cycle, remain IDLE, Ready stays 1, no line asserted.
  - DRIVE: the selected line is low, all others high. Counter decrements each cycle.
    - At 0 → GAP (counter = GAP_CYCLES-1), or → IDLE if GAP_CYCLES = 0.
  - GAP: all lines high. Counter decrements.
    - At 0 → IDLE.
- Cycle-level timing (accept at edge t):
  - Line low from t+1 through t+HOLD_CYCLES.
  - Lines high from t+HOLD_CYCLES+1.
  - Ready = 1 again at t+HOLD_CYCLES+GAP_CYCLES+1.
  - Accept-to-accept minimum = HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Busy = 1 in DRIVE and GAP. Ready = 0 in DRIVE and GAP.
- At most one line is low in any cycle. No glitch between codes; the gap guarantees all-high separation.
- Valid held while Ready = 0: ignored, no accept, no queueing. The source keeps Valid and Code stable until Ready.
- Code changing mid-DRIVE: no effect; the registered copy is used.
- EI rises at any time:
  - Next edge: state → IDLE, lines all high, Busy = 0, Ready = 0, counter cleared.
  - The aborted pulse is not resumed.
  - EI falling → Ready = 1 on the following edge.
- RESETn asserted mid-DRIVE: lines go high immediately (asynchronous), all state cleared.
- Width rules:
  - Counter is CNT_W bits. HOLD_CYCLES and GAP_CYCLES must be < 2^CNT_W; elaboration-time check.
  - Code compared unsigned against MAX_CODE. MAX_CODE = 15 disables Err.

Decomposition:
- Shared package hc_pkg:
  - state enum (IDLE, DRIVE, GAP).
  - LINES = 16, CODE_W = 4.
  - function line_onehot_n(code) returning the 16-bit active-low vector.
- hc_pkg is reused by the encoder model in the bench.
- One natural sub-module: hc154_decode. Combinational 4-to-16 active-low decode with enable, split into the DataOut/DataOut_0 halves, registered in the parent.
- FSM and counter stay in hc154_line_driver.

Test Plan:
- Reset then EI = 0, Valid = 1, Code = 3, HOLD = 4, GAP = 2 → DataOut_0 = 8'hF7 for exactly 4 cycles starting t+1, DataOut = 8'hFF throughout, Ready back high at t+7.
- Code = 9 (MAX_CODE = 9) → DataOut = 8'hFD for 4 cycles. Then Code = 12 → Err high one cycle, both buses stay 8'hFF, Ready stays 1.
- Back-to-back Valid held with codes 0 then 7 → second accept exactly 7 cycles after first, at least 2 all-high cycles between 8'hFE and 8'h7F on DataOut_0.
- EI driven high during cycle 2 of DRIVE (Code = 5) → next edge both buses 8'hFF, Busy = 0, Ready = 0. EI low → Ready = 1 one cycle later, no residual pulse.
- RESETn pulsed low mid-DRIVE (Code = 15) → DataOut = 8'hFF immediately without waiting for CLK. After release, Ready = 1 on the first edge.
- Loopback: output through the cascaded encoder/display model for codes 0..9 → displayed digit equals Code. Codes 10..15 with MAX_CODE = 15 → display blanked.

Source files
------------

// File: rtl/hc_pkg.sv
// hc_pkg: shared definitions for the HC154-style line driver and its bench.
//   LINES         - number of active-low output lines (16)
//   CODE_W        - width of a line code (4)
//   state_e       - driver FSM states (IDLE, DRIVE, GAP)
//   line_onehot_n - 16-bit active-low vector with only line `code` low
package hc_pkg;

  localparam int LINES  = 16;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [LINES-1:0] line_onehot_n(input logic [CODE_W-1:0] code);
    logic [LINES-1:0] v;
    v       = {LINES{1'b1}};
    v[code] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/hc154_decode.sv
// hc154_decode: combinational 4-to-16 active-low decoder with enable.
//   en_i     - 1 = drive the selected line low, 0 = all lines high
//   code_i   - line number 0..15
//   hi_n_o   - active-low lines 8..15 (line k on bit k-8)
//   lo_n_o   - active-low lines 0..7  (line k on bit k)
module hc154_decode
  import hc_pkg::*;
(
  input  logic              en_i,
  input  logic [CODE_W-1:0] code_i,
  output logic [7:0]        hi_n_o,
  output logic [7:0]        lo_n_o
);

  logic [LINES-1:0] lines_n_s;

  // Select one low line when enabled, otherwise keep every line released.
  always_comb begin
    lines_n_s = {LINES{1'b1}};
    if (en_i) begin
      lines_n_s = line_onehot_n(code_i);
    end else begin
      lines_n_s = {LINES{1'b1}};
    end
  end

  assign hi_n_o = lines_n_s[15:8];
  assign lo_n_o = lines_n_s[7:0];

endmodule

// File: rtl/hc154_line_driver.sv
// hc154_line_driver: accepts a 4-bit line code over valid/ready, pulses the
// matching active-low line for HOLD_CYCLES, then holds every line high for
// GAP_CYCLES before accepting again. Codes above MAX_CODE raise a one-cycle Err.
//   CLK        - clock, rising edge
//   RESETn     - asynchronous active-low reset
//   EI         - active-low enable; high aborts any pulse and blocks accepts
//   Code/Valid - request; accepted when Valid and Ready are both high at an edge
//   Ready      - high only in IDLE while EI is low
//   DataOut    - active-low lines 8..15, DataOut_0 - active-low lines 0..7
//   Busy       - high during DRIVE and GAP
//   Err        - one-cycle pulse after accepting an out-of-range code
// All outputs come straight from flops.
module hc154_line_driver
  import hc_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned MAX_CODE    = 9,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              EI,
  input  logic [CODE_W-1:0] Code,
  input  logic              Valid,
  output logic              Ready,
  output logic [7:0]        DataOut,
  output logic [7:0]        DataOut_0,
  output logic              Busy,
  output logic              Err
);

  // Elaboration-time parameter legality.
  if (HOLD_CYCLES < 32'd1 || HOLD_CYCLES >= (32'd1 << CNT_W)) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1 .. 2**CNT_W-1");
  end
  if (GAP_CYCLES >= (32'd1 << CNT_W)) begin : g_bad_gap
    $error("GAP_CYCLES must be below 2**CNT_W");
  end
  if (MAX_CODE > 32'd15) begin : g_bad_max
    $error("MAX_CODE must be in 0 .. 15");
  end

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD  =
    (GAP_CYCLES == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(GAP_CYCLES - 32'd1);
  localparam bit               HAS_GAP   = (GAP_CYCLES != 32'd0);
  // One bit wider than Code so MAX_CODE = 15 is not a degenerate compare.
  localparam logic [CODE_W:0]  MAX_W     = (CODE_W + 1)'(MAX_CODE);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [7:0]        hi_n_q, lo_n_q;
  logic [7:0]        hi_n_s, lo_n_s;
  logic              accept_s;
  logic              code_over_s;

  assign accept_s    = Valid & ready_q;
  assign code_over_s = ({1'b0, Code} > MAX_W);

  // Next-state, counter, captured code and status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    err_d   = 1'b0;
    if (EI) begin
      // Disable aborts immediately; the interrupted pulse is dropped.
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            code_d = Code;
            if (code_over_s) begin
              err_d = 1'b1;
            end else begin
              state_d = DRIVE;
              cnt_d   = HOLD_LOAD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DRIVE: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            if (HAS_GAP) begin
              state_d = GAP;
              cnt_d   = GAP_LOAD;
            end else begin
              state_d = IDLE;
              cnt_d   = {CNT_W{1'b0}};
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
    ready_d = (state_d == IDLE) && !EI;
    busy_d  = (state_d != IDLE);
  end

  // Lines are decoded from the next state so the pulse starts on the accept edge.
  hc154_decode u_decode (
    .en_i   (state_d == DRIVE),
    .code_i (code_d),
    .hi_n_o (hi_n_s),
    .lo_n_o (lo_n_s)
  );

  // State and output registers; reset releases every line at once.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      code_q  <= {CODE_W{1'b0}};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      hi_n_q  <= 8'hFF;
      lo_n_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      hi_n_q  <= hi_n_s;
      lo_n_q  <= lo_n_s;
    end
  end

  assign Ready     = ready_q;
  assign Busy      = busy_q;
  assign Err       = err_q;
  assign DataOut   = hi_n_q;
  assign DataOut_0 = lo_n_q;

endmodule

// File: tb/tb_hc154_line_driver.sv
// Bench for hc154_line_driver. dut1 (HOLD 4, GAP 2, MAX 9) is checked cycle by
// cycle against a timestamp-based reference model via a scoreboard queue;
// dut2 (HOLD 3, GAP 1, MAX 15) is used for loopback through an encoder/display
// model and for the asynchronous reset check.
module tb_hc154_line_driver;
  import hc_pkg::*;

  localparam int H1 = 4, G1 = 2, M1 = 9;
  localparam int H2 = 3, G2 = 1, M2 = 15;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       rdy;
    logic       busy;
    logic       err;
  } snap_t;

  logic CLK = 1'b0;
  logic RESETn = 1'b1;
  logic ei1 = 1'b0, v1 = 1'b0, ei2 = 1'b0, v2 = 1'b0;
  logic [3:0] c1 = 4'd0, c2 = 4'd0;
  logic rdy1, busy1, err1, rdy2, busy2, err2;
  logic [7:0] hi1, lo1, hi2, lo2;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  snap_t sb[$];
  int starts[$];

  always #5 CLK = ~CLK;

  hc154_line_driver #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1), .MAX_CODE(M1), .CNT_W(8)) dut1 (
    .CLK(CLK), .RESETn(RESETn), .EI(ei1), .Code(c1), .Valid(v1), .Ready(rdy1),
    .DataOut(hi1), .DataOut_0(lo1), .Busy(busy1), .Err(err1));

  hc154_line_driver #(.HOLD_CYCLES(H2), .GAP_CYCLES(G2), .MAX_CODE(M2), .CNT_W(8)) dut2 (
    .CLK(CLK), .RESETn(RESETn), .EI(ei2), .Code(c2), .Valid(v2), .Ready(rdy2),
    .DataOut(hi2), .DataOut_0(lo2), .Busy(busy2), .Err(err2));

  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- reference model for dut1 ----------------
  int  m_cyc = 0, m_t = 0, m_code = 0;
  bit  m_active = 1'b0, m_ready = 1'b0;

  always @(negedge RESETn) begin
    sb.delete();
    m_active = 1'b0;
    m_ready  = 1'b0;
  end

  always @(posedge CLK) begin
    snap_t s;
    logic [LINES-1:0] ln;
    bit busy, err;
    m_cyc++;
    if (!RESETn) begin
      s = '{hi: 8'hFF, lo: 8'hFF, rdy: 1'b0, busy: 1'b0, err: 1'b0};
      m_active = 1'b0;
      m_ready  = 1'b0;
    end else begin
      err = 1'b0;
      if (ei1) begin
        m_active = 1'b0;
      end else if (v1 && m_ready) begin
        if (int'(c1) > M1) err = 1'b1;
        else begin
          m_active = 1'b1;
          m_t      = m_cyc;
          m_code   = int'(c1);
        end
      end
      ln   = '1;
      busy = 1'b0;
      if (m_active) begin
        if (m_cyc < m_t + H1) begin
          ln   = ~(16'd1 << m_code);
          busy = 1'b1;
        end else if (m_cyc < m_t + H1 + G1) begin
          busy = 1'b1;
        end else begin
          m_active = 1'b0;
        end
      end
      m_ready = !busy && !ei1;
      s = '{hi: ln[15:8], lo: ln[7:0], rdy: m_ready, busy: busy, err: err};
    end
    sb.push_back(s);
  end

  // ---------------- monitor / scoreboard checker ----------------
  bit prev_high = 1'b1;
  always @(negedge CLK) begin
    snap_t e, a;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = '{hi: hi1, lo: lo1, rdy: rdy1, busy: busy1, err: err1};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard cyc=%0d got hi=%h lo=%h rdy=%b busy=%b err=%b want hi=%h lo=%h rdy=%b busy=%b err=%b",
                 cyc, a.hi, a.lo, a.rdy, a.busy, a.err, e.hi, e.lo, e.rdy, e.busy, e.err);
      end
    end
    if (prev_high && ({hi1, lo1} != 16'hFFFF)) starts.push_back(cyc);
    prev_high = ({hi1, lo1} == 16'hFFFF);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Called at a negedge; holds Valid/Code until a handshake edge has passed.
  task automatic send(input bit u2, input logic [3:0] c);
    bit done;
    done = 1'b0;
    if (u2) begin v2 = 1'b1; c2 = c; end else begin v1 = 1'b1; c1 = c; end
    for (int k = 0; k < 60 && !done; k++) begin
      if ((u2 ? rdy2 : rdy1) == 1'b1) done = 1'b1;
      @(negedge CLK);
    end
    if (u2) v2 = 1'b0; else v1 = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout code=%0d got Ready=0 want Ready=1 within 60 cycles", c);
    end
  endtask

  // Cascaded priority encoder (highest low line wins) followed by a display
  // that shows 0..9 and blanks everything else (-1 = blank).
  function automatic int enc_display(input logic [LINES-1:0] ln_n);
    int code;
    code = -1;
    for (int k = 0; k < LINES; k++) if (!ln_n[k]) code = k;
    return (code >= 0 && code <= 9) ? code : -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    #1 RESETn = 1'b0;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    // Directed sequence on dut1; timing is checked by the scoreboard.
    send(1'b0, 4'd3);
    send(1'b0, 4'd9);
    send(1'b0, 4'd12);
    send(1'b0, 4'd0);
    send(1'b0, 4'd7);
    repeat (2) @(negedge CLK);
    if (starts.size() >= 2)
      chk("accept_spacing", starts[starts.size()-1] - starts[starts.size()-2], H1 + G1 + 1);
    else
      chk("pulse_starts_seen", starts.size(), 2);
    repeat (8) @(negedge CLK);

    // EI abort in the second DRIVE cycle.
    send(1'b0, 4'd5);
    @(negedge CLK);
    ei1 = 1'b1;
    repeat (3) @(negedge CLK);
    ei1 = 1'b0;
    repeat (10) @(negedge CLK);

    // Loopback through the encoder/display model on dut2 (MAX_CODE 15).
    for (int c = 0; c < 16; c++) begin
      send(1'b1, 4'(c));
      chk($sformatf("loopback_%0d", c), enc_display({hi2, lo2}), (c <= 9) ? c : -1);
    end
    repeat (6) @(negedge CLK);

    // Asynchronous reset in the middle of a line-15 pulse.
    send(1'b1, 4'd15);
    chk("drive15_hi", int'(hi2), 8'h7F);
    #2 RESETn = 1'b0;
    #1;
    chk("async_rst_hi", int'(hi2), 8'hFF);
    chk("async_rst_lo", int'(lo2), 8'hFF);
    chk("async_rst_busy", int'(busy2), 0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK);
    #1 chk("ready_after_rst", int'(rdy2), 1);
    @(negedge CLK);

    // Randomized traffic on dut1, including occasional EI pulses.
    for (int i = 0; i < 400; i++) begin
      v1  = 1'($urandom_range(0, 1));
      c1  = 4'($urandom_range(0, 15));
      ei1 = ($urandom_range(0, 19) == 0);
      @(negedge CLK);
    end
    v1  = 1'b0;
    ei1 = 1'b0;
    repeat (12) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
